// File: rtl/shift_exec_stage_pkg.sv
// Shared definitions for the shift execute stage: funct codes, shifter op
// encodings, pipeline occupancy states and the funct legality decode.
package shift_exec_stage_pkg;

    localparam int SHIFT_W = 32;
    localparam int SHAMT_W = 5;

    // R-type funct codes handled by this stage
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;

    // Shifter operation, taken straight from funct[1:0]
    localparam logic [1:0] SHIFTOP_SLL = 2'b00;
    localparam logic [1:0] SHIFTOP_SRL = 2'b10;
    localparam logic [1:0] SHIFTOP_SRA = 2'b11;

    // Occupancy of the output register and skid register
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    // Only the six shift codes are legal; everything else is flagged
    function automatic logic funct_is_legal(input logic [5:0] funct);
        logic legal;
        case (funct)
            FUNCT_SLL, FUNCT_SRL, FUNCT_SRA,
            FUNCT_SLLV, FUNCT_SRLV, FUNCT_SRAV: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/shift_exec_stage_shifter.sv
// 32-bit combinational barrel shifter. Left shifts are done by bit-reversing
// the operand, shifting right, and reversing back, so a single right-shift
// ladder serves all three operations.
module shift_exec_stage_shifter
    import shift_exec_stage_pkg::*;
(
    input  logic [SHIFT_W-1:0] A,
    input  logic [SHAMT_W-1:0] B,
    input  logic [1:0]         Shiftop,
    output logic [SHIFT_W-1:0] Result
);

    logic               is_left;
    logic               fill_bit;
    logic [SHIFT_W-1:0] a_rev;
    logic [SHIFT_W-1:0] ladder_out;
    logic [SHIFT_W-1:0] ladder_rev;

    // Decode the operation into direction and the bit shifted in from the top
    always_comb begin
        is_left  = 1'b0;
        fill_bit = 1'b0;
        case (Shiftop)
            SHIFTOP_SLL: is_left  = 1'b1;
            SHIFTOP_SRA: fill_bit = A[SHIFT_W-1];
            SHIFTOP_SRL: fill_bit = 1'b0;
            default:     fill_bit = 1'b0;
        endcase
    end

    // Bit reversal of the operand and of the ladder output for left shifts
    genvar gi;
    generate
        for (gi = 0; gi < SHIFT_W; gi++) begin : g_rev
            assign a_rev[gi]      = A[SHIFT_W-1-gi];
            assign ladder_rev[gi] = ladder_out[SHIFT_W-1-gi];
        end
    endgenerate

    // Log-depth right-shift ladder: stage i shifts by 2**i when B[i] is set
    always_comb begin
        logic [SHIFT_W-1:0] cur;
        cur = is_left ? a_rev : A;
        for (int i = 0; i < SHAMT_W; i++) begin
            if (B[i]) begin
                cur = (cur >> (1 << i)) |
                      (fill_bit ? ~({SHIFT_W{1'b1}} >> (1 << i)) : {SHIFT_W{1'b0}});
            end
        end
        ladder_out = cur;
    end

    assign Result = is_left ? ladder_rev : ladder_out;

endmodule

// File: rtl/shift_exec_stage.sv
// Execute stage for R-type shifts: decodes funct, picks the shift amount,
// computes on the input side and holds results in an output register backed
// by one skid entry so the stage streams one shift per cycle under
// valid/ready back-pressure while in_ready stays a pure state decode.
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_funct,
    input  logic [4:0]            in_shamt,
    input  logic [DATA_WIDTH-1:0] in_rs_val,
    input  logic [DATA_WIDTH-1:0] in_rt_val,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_illegal
);

    state_t                state_reg, state_next;
    logic                  accept;
    logic                  load_out_from_in;
    logic                  load_out_from_skid;
    logic                  load_skid;

    logic [4:0]            shift_amount;
    logic [DATA_WIDTH-1:0] shift_result;
    logic                  in_legal;
    logic [DATA_WIDTH-1:0] in_entry_result;
    logic                  unused_rs_bits;

    logic [DATA_WIDTH-1:0] out_result_reg;
    logic [REG_ADDR_W-1:0] out_rd_reg;
    logic                  out_illegal_reg;
    logic [DATA_WIDTH-1:0] skid_result_reg;
    logic [REG_ADDR_W-1:0] skid_rd_reg;
    logic                  skid_illegal_reg;

    // Variable shifts take only rs[4:0]; the rest of rs is deliberately ignored
    assign shift_amount   = in_funct[2] ? in_rs_val[4:0] : in_shamt;
    assign unused_rs_bits = ^in_rs_val[DATA_WIDTH-1:5];

    shift_exec_stage_shifter u_shifter (
        .A       (in_rt_val),
        .B       (shift_amount),
        .Shiftop (in_funct[1:0]),
        .Result  (shift_result)
    );

    assign in_legal        = funct_is_legal(in_funct);
    assign in_entry_result = in_legal ? shift_result : {DATA_WIDTH{1'b0}};

    // Handshake signals decode only the state register, never out_ready
    assign in_ready  = (state_reg != ST_FULL);
    assign out_valid = (state_reg != ST_EMPTY);
    assign accept    = in_valid & in_ready;

    // Occupancy state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and register-load decode; flush overrides every transition
    always_comb begin
        state_next         = state_reg;
        load_out_from_in   = 1'b0;
        load_out_from_skid = 1'b0;
        load_skid          = 1'b0;
        case (state_reg)
            ST_EMPTY: begin
                if (accept) begin
                    state_next       = ST_ONE;
                    load_out_from_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && out_ready) begin
                    load_out_from_in = 1'b1;
                end else if (accept) begin
                    state_next = ST_FULL;
                    load_skid  = 1'b1;
                end else if (out_ready) begin
                    state_next = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    state_next         = ST_ONE;
                    load_out_from_skid = 1'b1;
                end
            end
            default: state_next = ST_EMPTY;
        endcase
        if (flush) begin
            state_next         = ST_EMPTY;
            load_out_from_in   = 1'b0;
            load_out_from_skid = 1'b0;
            load_skid          = 1'b0;
        end
    end

    // Output and skid data registers; a flush also clears them so nothing stale lingers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_result_reg   <= '0;
            out_rd_reg       <= '0;
            out_illegal_reg  <= 1'b0;
            skid_result_reg  <= '0;
            skid_rd_reg      <= '0;
            skid_illegal_reg <= 1'b0;
        end else if (flush) begin
            out_result_reg   <= '0;
            out_rd_reg       <= '0;
            out_illegal_reg  <= 1'b0;
            skid_result_reg  <= '0;
            skid_rd_reg      <= '0;
            skid_illegal_reg <= 1'b0;
        end else begin
            if (load_out_from_in) begin
                out_result_reg  <= in_entry_result;
                out_rd_reg      <= in_rd;
                out_illegal_reg <= ~in_legal;
            end else if (load_out_from_skid) begin
                out_result_reg  <= skid_result_reg;
                out_rd_reg      <= skid_rd_reg;
                out_illegal_reg <= skid_illegal_reg;
            end
            if (load_skid) begin
                skid_result_reg  <= in_entry_result;
                skid_rd_reg      <= in_rd;
                skid_illegal_reg <= ~in_legal;
            end
        end
    end

    assign out_result  = out_result_reg;
    assign out_rd      = out_rd_reg;
    assign out_illegal = out_illegal_reg;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Scoreboard bench for shift_exec_stage: accepted instructions push an
// expected entry computed from plain shift arithmetic; a negedge monitor pops
// and compares on every output handshake, and also checks occupancy-derived
// in_ready/out_valid and output stability under back-pressure.
module tb_shift_exec_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  in_funct;
    logic [4:0]  in_shamt;
    logic [31:0] in_rs_val;
    logic [31:0] in_rt_val;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_pops = 0;
    logic hold_pending = 1'b0;
    exp_t hold_val;

    logic [5:0] legal_f [6] = '{6'b000000, 6'b000010, 6'b000011,
                                6'b000100, 6'b000110, 6'b000111};

    shift_exec_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_funct    (in_funct),
        .in_shamt    (in_shamt),
        .in_rs_val   (in_rs_val),
        .in_rt_val   (in_rt_val),
        .in_rd       (in_rd),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    // Reference: what an R-type shift instruction computes
    function automatic exp_t model(input logic [5:0] funct, input logic [4:0] shamt,
                                   input logic [31:0] rs, input logic [31:0] rt,
                                   input logic [4:0] rd);
        exp_t              e;
        logic signed [31:0] srt;
        logic [4:0]         vamt;
        srt       = rt;
        vamt      = rs[4:0];
        e.rd      = rd;
        e.illegal = 1'b0;
        case (funct)
            6'b000000: e.result = rt << shamt;
            6'b000010: e.result = rt >> shamt;
            6'b000011: e.result = srt >>> shamt;
            6'b000100: e.result = rt << vamt;
            6'b000110: e.result = rt >> vamt;
            6'b000111: e.result = srt >>> vamt;
            default: begin
                e.result  = 32'h0;
                e.illegal = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor/scoreboard: evaluates the handshakes that the next rising edge will perform
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            hold_pending = 1'b0;
        end else begin
            chk("out_valid_occupancy", 32'(out_valid), 32'(sb_q.size() != 0));
            chk("in_ready_occupancy", 32'(in_ready), 32'(sb_q.size() < 2));
            if (hold_pending) begin
                chk("hold_result", out_result, hold_val.result);
                chk("hold_rd", 32'(out_rd), 32'(hold_val.rd));
                chk("hold_illegal", 32'(out_illegal), 32'(hold_val.illegal));
            end
            hold_pending = out_valid && !out_ready && !flush;
            hold_val     = '{result: out_result, rd: out_rd, illegal: out_illegal};
            if (out_valid && out_ready && sb_q.size() != 0) begin
                exp_t e;
                e = sb_q.pop_front();
                n_pops++;
                chk("sb_result", out_result, e.result);
                chk("sb_rd", 32'(out_rd), 32'(e.rd));
                chk("sb_illegal", 32'(out_illegal), 32'(e.illegal));
            end
            if (flush) begin
                sb_q.delete();
            end else if (in_valid && in_ready) begin
                sb_q.push_back(model(in_funct, in_shamt, in_rs_val, in_rt_val, in_rd));
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] rd);
        in_funct  = f;
        in_shamt  = sa;
        in_rs_val = rs;
        in_rt_val = rt;
        in_rd     = rd;
        in_valid  = 1'b1;
        cycle();
        in_valid  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        for (int i = 0; i < 30 && (sb_q.size() != 0 || out_valid); i++) cycle();
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic randomize_inputs();
        in_funct = ($urandom_range(0, 4) != 0) ? legal_f[$urandom_range(0, 5)]
                                               : 6'($urandom_range(0, 63));
        case ($urandom_range(0, 3))
            0:       in_shamt = 5'd0;
            1:       in_shamt = 5'd31;
            default: in_shamt = 5'($urandom_range(0, 31));
        endcase
        in_rs_val = $urandom;
        if ($urandom_range(0, 3) == 0) in_rs_val[4:0] = ($urandom_range(0, 1) != 0) ? 5'd31 : 5'd0;
        in_rt_val = $urandom;
        in_rd     = 5'($urandom_range(0, 31));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_funct  = 6'd0;
        in_shamt  = 5'd0;
        in_rs_val = 32'd0;
        in_rt_val = 32'd0;
        in_rd     = 5'd0;
        repeat (3) cycle();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_out_rd", 32'(out_rd), 32'd0);
        chk("reset_out_illegal", 32'(out_illegal), 32'd0);
        rst_n = 1'b1;
        cycle();

        // SLL by 31, result visible the cycle after acceptance
        out_ready = 1'b1;
        issue(6'b000000, 5'd31, 32'h0, 32'h0000_0001, 5'd3);
        chk("sll31_valid", 32'(out_valid), 32'd1);
        chk("sll31_result", out_result, 32'h8000_0000);
        chk("sll31_rd", 32'(out_rd), 32'd3);

        // Variable shifts use rs[4:0] only
        issue(6'b000111, 5'd9, 32'hFFFF_FFE4, 32'h8000_00F0, 5'd4);
        chk("srav4_result", out_result, 32'hF800_000F);
        issue(6'b000110, 5'd9, 32'hFFFF_FFE4, 32'h8000_00F0, 5'd5);
        chk("srlv4_result", out_result, 32'h0800_000F);
        cycle();

        // Back-pressure: two accepted, third stalls until the output drains
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_funct  = 6'b000010;
            in_shamt  = 5'($urandom_range(0, 31));
            in_rt_val = $urandom;
            in_rd     = 5'(10 + i);
            chk("bp_in_ready", 32'(in_ready), (i < 2) ? 32'd1 : 32'd0);
            cycle();
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_in_ready_after_drain", 32'(in_ready), 32'd1);
        cycle();
        in_valid = 1'b0;
        drain();

        // Streaming: sixteen back-to-back shifts, one result per cycle
        begin
            int n0;
            n0        = n_pops;
            out_ready = 1'b1;
            for (int i = 0; i < 16; i++) begin
                randomize_inputs();
                in_funct = legal_f[i % 6];
                in_valid = 1'b1;
                chk("stream_in_ready", 32'(in_ready), 32'd1);
                cycle();
            end
            in_valid = 1'b0;
            cycle();
            chk("stream_count", 32'(n_pops - n0), 32'd16);
        end
        drain();

        // Illegal funct and amount edges
        issue(6'b000001, 5'd5, 32'h0, 32'h0000_FFFF, 5'd7);
        chk("illegal_flag", 32'(out_illegal), 32'd1);
        chk("illegal_result", out_result, 32'd0);
        chk("illegal_rd", 32'(out_rd), 32'd7);
        issue(6'b000000, 5'd0, 32'h0, 32'h1234_5678, 5'd9);
        chk("sll0_result", out_result, 32'h1234_5678);
        issue(6'b000011, 5'd31, 32'h0, 32'h8000_0000, 5'd1);
        chk("sra31_result", out_result, 32'hFFFF_FFFF);
        issue(6'b000110, 5'd0, 32'hFFFF_FFE0, 32'hCAFE_F00D, 5'd2);
        chk("srlv_rs_upper_ignored", out_result, 32'hCAFE_F00D);
        drain();

        // Flush from FULL with a simultaneous offer: everything squashed
        out_ready = 1'b0;
        issue(6'b000010, 5'd1, 32'h0, 32'h0000_0010, 5'd11);
        issue(6'b000010, 5'd2, 32'h0, 32'h0000_0020, 5'd12);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_full_out_valid", 32'(out_valid), 32'd0);
        chk("flush_full_in_ready", 32'(in_ready), 32'd1);
        // Flush from ONE drops the instruction accepted in the same cycle
        issue(6'b000000, 5'd3, 32'h0, 32'h0000_0001, 5'd13);
        in_valid = 1'b1;
        flush    = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_one_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        issue(6'b000010, 5'd4, 32'h0, 32'h0000_00F0, 5'd2);
        chk("post_flush_result", out_result, 32'h0000_000F);
        chk("post_flush_rd", 32'(out_rd), 32'd2);
        drain();

        // Asynchronous reset mid-stream clears outputs without waiting for a clock
        out_ready = 1'b0;
        issue(6'b000000, 5'd4, 32'h0, 32'h0000_0003, 5'd21);
        in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", 32'(out_valid), 32'd0);
        chk("async_rst_out_result", out_result, 32'd0);
        chk("async_rst_out_rd", 32'(out_rd), 32'd0);
        chk("async_rst_out_illegal", 32'(out_illegal), 32'd0);
        chk("async_rst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);

        // Randomized traffic with back-pressure and occasional flushes
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
